// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - two-stage post-add mantissa normalizer with exponent adjust
module fp_normalizer #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [MANT_W:0]   mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              zero,
    output logic              uf,
    output logic              ovf
);

    localparam int LZC_W = $clog2(MANT_W + 1);
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    // Stage 1 registers
    logic              s1_vld_q,   s1_vld_d;
    logic              s1_carry_q, s1_carry_d;
    logic [MANT_W-1:0] s1_mant_q,  s1_mant_d;
    logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
    logic [LZC_W-1:0]  s1_lzc_q,   s1_lzc_d;

    // Output registers
    logic              out_vld_q,  out_vld_d;
    logic [MANT_W-1:0] mant_out_q, mant_out_d;
    logic [EXP_W-1:0]  exp_out_q,  exp_out_d;
    logic              zero_q,     zero_d;
    logic              uf_q,       uf_d;
    logic              ovf_q,      ovf_d;

    logic s1_adv;
    logic s2_adv;
    logic s1_load;
    logic s2_load;

    assign s2_adv  = !out_vld_q | out_rdy;
    assign s1_adv  = !s1_vld_q | s2_adv;
    assign in_rdy  = rst_n & s1_adv;
    assign s1_load = in_vld & in_rdy;
    assign s2_load = s1_vld_q & s2_adv;

    // Leading-zero count of the 24-bit field; the highest set bit wins.
    logic [LZC_W-1:0] lzc_in;
    always_comb begin
        lzc_in = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (mant_in[i]) begin
                lzc_in = LZC_W'(MANT_W - 1 - i);
            end
        end
    end

    always_comb begin
        s1_vld_d   = s1_adv ? in_vld : s1_vld_q;
        s1_carry_d = s1_carry_q;
        s1_mant_d  = s1_mant_q;
        s1_exp_d   = s1_exp_q;
        s1_lzc_d   = s1_lzc_q;
        if (s1_load) begin
            s1_carry_d = mant_in[MANT_W];
            s1_mant_d  = mant_in[MANT_W-1:0];
            s1_exp_d   = exp_in;
            s1_lzc_d   = lzc_in;
        end
    end

    // Logarithmic left shifter: one stage per lzc bit, zero fill.
    logic [MANT_W-1:0] mant_shl;
    always_comb begin
        mant_shl = s1_mant_q;
        for (int s = 0; s < LZC_W; s++) begin
            if (s1_lzc_q[s]) begin
                mant_shl = mant_shl << (1 << s);
            end
        end
    end

    // Exponent arithmetic one bit wider so carry into 2^EXP_W is visible.
    logic [EXP_W:0]   exp_ext;
    logic [EXP_W:0]   exp_inc;
    logic [EXP_W:0]   lzc_ext;
    logic [EXP_W-1:0] exp_dec;

    assign exp_ext = {1'b0, s1_exp_q};
    assign exp_inc = exp_ext + (EXP_W + 1)'(1);
    assign lzc_ext = (EXP_W + 1)'(s1_lzc_q);
    assign exp_dec = s1_exp_q - EXP_W'(s1_lzc_q);

    always_comb begin
        out_vld_d  = s2_adv ? s1_vld_q : out_vld_q;
        mant_out_d = mant_out_q;
        exp_out_d  = exp_out_q;
        zero_d     = zero_q;
        uf_d       = uf_q;
        ovf_d      = ovf_q;
        if (s2_load) begin
            mant_out_d = '0;
            exp_out_d  = '0;
            zero_d     = 1'b0;
            uf_d       = 1'b0;
            ovf_d      = 1'b0;
            if (s1_carry_q) begin
                if (exp_inc >= EXP_MAX) begin
                    ovf_d     = 1'b1;
                    exp_out_d = {EXP_W{1'b1}};
                end else begin
                    mant_out_d = {s1_carry_q, s1_mant_q[MANT_W-1:1]};
                    exp_out_d  = exp_inc[EXP_W-1:0];
                end
            end else if (s1_mant_q == '0) begin
                zero_d = 1'b1;
            end else if (lzc_ext >= exp_ext) begin
                // Result exponent would be <= 0: flush the denormal to zero.
                zero_d = 1'b1;
                uf_d   = 1'b1;
            end else begin
                mant_out_d = mant_shl;
                exp_out_d  = exp_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_carry_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_lzc_q   <= '0;
            out_vld_q  <= 1'b0;
            mant_out_q <= '0;
            exp_out_q  <= '0;
            zero_q     <= 1'b0;
            uf_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_carry_q <= s1_carry_d;
            s1_mant_q  <= s1_mant_d;
            s1_exp_q   <= s1_exp_d;
            s1_lzc_q   <= s1_lzc_d;
            out_vld_q  <= out_vld_d;
            mant_out_q <= mant_out_d;
            exp_out_q  <= exp_out_d;
            zero_q     <= zero_d;
            uf_q       <= uf_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign mant_out = mant_out_q;
    assign exp_out  = exp_out_q;
    assign zero     = zero_q;
    assign uf       = uf_q;
    assign ovf      = ovf_q;

endmodule
